mult_unit: RTL

//  Iterative shift-add multiplier beside register_file. Consumes busA/busB

---
 rtl/mult_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// Iterative 32-step shift-add multiplier with HI/LO result registers and MTHI/MTLO loads.
// Optional signed multiply is enabled by defining MULT_SIGNED_EN.
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [0:WIDTH-1] op_a,
  input  logic [0:WIDTH-1] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [0:WIDTH-1] hi,
  output logic [0:WIDTH-1] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST_C  = CNT_W'(WIDTH-1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, acc_hi, acc_lo;
  logic               neg;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod_raw, prod;

  // Sign handling happens at start only; the iteration is always unsigned.
  always_comb begin
`ifdef MULT_SIGNED_EN
    sgn = signed_op;
`else
    sgn = signed_op & 1'b0;
`endif
    abs_a = (sgn && op_a[0]) ? (~op_a + ONE_W) : op_a;
    abs_b = (sgn && op_b[0]) ? (~op_b + ONE_W) : op_b;
  end

  // acc_lo starts as the multiplier and fills with product bits as it shifts out.
  always_comb begin
    sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    nxt_hi   = sum[WIDTH:1];
    nxt_lo   = {sum[0], acc_lo[WIDTH-1:1]};
    prod_raw = {nxt_hi, nxt_lo};
    prod     = neg ? (~prod_raw + ONE_P) : prod_raw;
    last     = (cnt == LAST_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUSY;
      S_BUSY:  if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= abs_a;
            acc_lo <= abs_b;
            acc_hi <= '0;
            neg    <= sgn & (op_a[0] ^ op_b[0]);
            cnt    <= '0;
          end else begin
            if (hi_we) hi <= op_a;
            if (lo_we) lo <= op_a;
          end
        end
        S_BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + ONE_C;
          if (last) {hi, lo} <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule
